// File: rtl/task_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : task_sequencer
// Purpose  : Debounced next/prev task selector that drives the 3-bit mux flag.
//            Optional auto-cycling is built when AUTO_CYCLE_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module task_sequencer #(
   parameter int NUM_TASKS       = 5,
   parameter int DEBOUNCE_CYCLES = 100000,
   parameter int AUTO_PERIOD     = 200000000
) (
   input  logic       CLOCK,
   input  logic       RESET_N,
   input  logic       btn_next,
   input  logic       btn_prev,
   input  logic       sw_lock,
   input  logic       sw_auto,
   output logic [2:0] flag,
   output logic       flag_changed,
   output logic       busy
);

   localparam int         c_CNT_W     = $clog2(DEBOUNCE_CYCLES);
   localparam [c_CNT_W-1:0] c_DB_LAST = c_CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam [2:0]       c_LAST_TASK = 3'(NUM_TASKS - 1);

   localparam [1:0] c_IDLE         = 2'd0;
   localparam [1:0] c_DEBOUNCE     = 2'd1;
   localparam [1:0] c_COMMIT       = 2'd2;
   localparam [1:0] c_WAIT_RELEASE = 2'd3;

   logic [1:0]         r_state, w_state_next;
   logic               r_sn_meta, r_sn, r_sp_meta, r_sp;
   logic               r_dir, w_dir_next;       // 1 = next, 0 = prev
   logic [c_CNT_W-1:0] r_cnt, w_cnt_next;
   logic               w_own, w_other, w_step, w_auto_step, w_pulse;
   logic [2:0]         w_flag_inc, w_flag_dec, w_flag_next;

   always_ff @(posedge CLOCK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_sn_meta <= 1'b0;
         r_sn      <= 1'b0;
         r_sp_meta <= 1'b0;
         r_sp      <= 1'b0;
      end else begin
         r_sn_meta <= btn_next;
         r_sn      <= r_sn_meta;
         r_sp_meta <= btn_prev;
         r_sp      <= r_sp_meta;
      end
   end

   always_ff @(posedge CLOCK or negedge RESET_N) begin
      if (!RESET_N) r_state <= c_IDLE;
      else          r_state <= w_state_next;
   end

   assign w_own   = r_dir ? r_sn : r_sp;
   assign w_other = r_dir ? r_sp : r_sn;

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         c_IDLE:         if (r_sn ^ r_sp) w_state_next = c_DEBOUNCE;
         c_DEBOUNCE: begin
            if (!w_own || w_other)    w_state_next = c_IDLE;
            else if (r_cnt == c_DB_LAST) w_state_next = c_COMMIT;
         end
         c_COMMIT:       w_state_next = c_WAIT_RELEASE;
         default:        if (!(r_sn | r_sp) && (r_cnt == c_DB_LAST)) w_state_next = c_IDLE;
      endcase
   end

   always_comb begin
      w_cnt_next = r_cnt;
      w_dir_next = r_dir;
      case (r_state)
         c_IDLE: begin
            w_cnt_next = '0;
            if (r_sn ^ r_sp) w_dir_next = r_sn;
         end
         c_DEBOUNCE:
            w_cnt_next = (w_state_next == c_DEBOUNCE) ? r_cnt + 1'b1 : '0;
         c_COMMIT:
            w_cnt_next = '0;
         default:
            w_cnt_next = ((r_sn | r_sp) || (r_cnt == c_DB_LAST)) ? '0 : r_cnt + 1'b1;
      endcase
   end

   assign busy       = (r_state != c_IDLE);
   assign w_step     = (r_state == c_COMMIT) && !sw_lock;
   assign w_flag_inc = (flag == c_LAST_TASK) ? 3'd0 : flag + 3'd1;
   assign w_flag_dec = (flag == 3'd0) ? c_LAST_TASK : flag - 3'd1;

`ifdef AUTO_CYCLE_EN
   localparam int           c_AUTO_W    = $clog2(AUTO_PERIOD);
   localparam [c_AUTO_W-1:0] c_AUTO_LAST = c_AUTO_W'(AUTO_PERIOD - 1);

   logic [c_AUTO_W-1:0] r_auto_cnt;
   logic                w_auto_run;

   assign w_auto_run  = (r_state == c_IDLE) && sw_auto && !sw_lock;
   assign w_auto_step = w_auto_run && (r_auto_cnt == c_AUTO_LAST);

   // Counter restarts whenever the FSM leaves IDLE, so a press resets the period.
   always_ff @(posedge CLOCK or negedge RESET_N) begin
      if (!RESET_N)
         r_auto_cnt <= '0;
      else if (!w_auto_run || w_auto_step || (w_state_next != c_IDLE))
         r_auto_cnt <= '0;
      else
         r_auto_cnt <= r_auto_cnt + 1'b1;
   end
`else
   localparam int c_unused_auto_period = AUTO_PERIOD;
   logic          w_unused_auto;

   assign w_unused_auto = sw_auto;
   assign w_auto_step   = 1'b0;
`endif

   always_comb begin
      w_flag_next = flag;
      w_pulse     = 1'b0;
      if (w_step) begin
         w_flag_next = r_dir ? w_flag_inc : w_flag_dec;
         w_pulse     = 1'b1;
      end else if (w_auto_step) begin
         w_flag_next = w_flag_inc;
         w_pulse     = 1'b1;
      end
   end

   always_ff @(posedge CLOCK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_cnt        <= '0;
         r_dir        <= 1'b0;
         flag         <= 3'd0;
         flag_changed <= 1'b0;
      end else begin
         r_cnt        <= w_cnt_next;
         r_dir        <= w_dir_next;
         flag         <= w_flag_next;
         flag_changed <= w_pulse;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_task_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_task_sequencer
// Purpose  : Directed self-checking bench for task_sequencer (D=4, N=5, P=10).
// Revision : 1.0 - initial release
// ============================================================================
module tb_task_sequencer;

   logic       CLOCK = 1'b0;
   logic       RESET_N = 1'b0;
   logic       btn_next = 1'b0;
   logic       btn_prev = 1'b0;
   logic       sw_lock = 1'b0;
   logic       sw_auto = 1'b0;
   logic [2:0] flag;
   logic       flag_changed;
   logic       busy;

   int n_checks = 0;
   int n_fail   = 0;

   task_sequencer #(
      .NUM_TASKS      (5),
      .DEBOUNCE_CYCLES(4),
      .AUTO_PERIOD    (10)
   ) dut (
      .CLOCK       (CLOCK),
      .RESET_N     (RESET_N),
      .btn_next    (btn_next),
      .btn_prev    (btn_prev),
      .sw_lock     (sw_lock),
      .sw_auto     (sw_auto),
      .flag        (flag),
      .flag_changed(flag_changed),
      .busy        (busy)
   );

   always #5 CLOCK = ~CLOCK;

   task automatic tick();
      @(posedge CLOCK);
      #1;
   endtask

   task automatic do_reset(input logic auto_en);
      btn_next = 1'b0;
      btn_prev = 1'b0;
      sw_lock  = 1'b0;
      sw_auto  = auto_en;
      RESET_N  = 1'b0;
      tick();
      tick();
      RESET_N  = 1'b1;
   endtask

   // One clean press: hold 10 cycles, release, let WAIT_RELEASE drain.
   task automatic press(input logic is_next, input logic [2:0] exp, input string name);
      int pulses = 0;
      btn_next = is_next;
      btn_prev = !is_next;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (flag_changed) pulses++;
      end
      n_checks++;
      if (flag !== exp) begin
         n_fail++;
         $display("FAIL %s flag: got %0d want %0d", name, flag, exp);
      end
      btn_next = 1'b0;
      btn_prev = 1'b0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (flag_changed) pulses++;
      end
      n_checks++;
      if (pulses !== 1 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL %s pulses/busy: got %0d/%b want 1/0", name, pulses, busy);
      end
   endtask

   task automatic test_reset();
      do_reset(1'b0);
      n_checks++;
      if (flag !== 3'd0 || flag_changed !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_state: got flag=%0d fc=%b busy=%b want 0/0/0", flag, flag_changed, busy);
      end
   endtask

   task automatic test_latency_hold();
      int pulses = 0;
      do_reset(1'b0);
      btn_next = 1'b1;
      for (int i = 0; i < 7; i++) tick();  // edges 0..6
      n_checks++;
      if (flag !== 3'd0 || flag_changed !== 1'b0) begin
         n_fail++;
         $display("FAIL latency_early: got flag=%0d fc=%b want 0/0", flag, flag_changed);
      end
      tick();                               // edge 7
      n_checks++;
      if (flag !== 3'd1 || flag_changed !== 1'b1) begin
         n_fail++;
         $display("FAIL latency_edge7: got flag=%0d fc=%b want 1/1", flag, flag_changed);
      end
      tick();
      n_checks++;
      if (flag_changed !== 1'b0) begin
         n_fail++;
         $display("FAIL pulse_width: got fc=%b want 0", flag_changed);
      end
      for (int i = 0; i < 50; i++) begin
         tick();
         if (flag_changed) pulses++;
      end
      n_checks++;
      if (flag !== 3'd1 || pulses !== 0) begin
         n_fail++;
         $display("FAIL hold_no_repeat: got flag=%0d pulses=%0d want 1/0", flag, pulses);
      end
      btn_next = 1'b0;
      for (int i = 0; i < 12; i++) tick();
      n_checks++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL hold_release_idle: got busy=%b want 0", busy);
      end
   endtask

   task automatic test_wrap();
      logic [2:0] exp_seq [5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
      do_reset(1'b0);
      for (int i = 0; i < 5; i++) press(1'b1, exp_seq[i], $sformatf("next_%0d", i));
      press(1'b0, 3'd4, "prev_wrap");
   endtask

   task automatic test_glitch();
      int pulses = 0;
      do_reset(1'b0);
      btn_next = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (flag_changed) pulses++;
      end
      btn_next = 1'b0;
      for (int i = 0; i < 15; i++) begin
         tick();
         if (flag_changed) pulses++;
      end
      n_checks++;
      if (flag !== 3'd0 || pulses !== 0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL glitch: got flag=%0d pulses=%0d busy=%b want 0/0/0", flag, pulses, busy);
      end
   endtask

   task automatic test_both_buttons();
      int busy_seen = 0;
      int pulses = 0;
      do_reset(1'b0);
      btn_next = 1'b1;
      btn_prev = 1'b1;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (busy) busy_seen++;
         if (flag_changed) pulses++;
      end
      btn_next = 1'b0;
      btn_prev = 1'b0;
      for (int i = 0; i < 12; i++) tick();
      n_checks++;
      if (flag !== 3'd0 || pulses !== 0 || busy_seen !== 0) begin
         n_fail++;
         $display("FAIL both_buttons: got flag=%0d pulses=%0d busy_cycles=%0d want 0/0/0", flag, pulses, busy_seen);
      end
   endtask

   task automatic test_lock();
      int busy_seen = 0;
      int pulses = 0;
      do_reset(1'b0);
      press(1'b1, 3'd1, "lock_setup");
      sw_lock  = 1'b1;
      btn_next = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (busy) busy_seen++;
         if (flag_changed) pulses++;
      end
      btn_next = 1'b0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (flag_changed) pulses++;
      end
      n_checks++;
      if (flag !== 3'd1 || pulses !== 0 || busy_seen == 0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL lock: got flag=%0d pulses=%0d busy_cycles=%0d busy=%b want 1/0/>0/0",
                  flag, pulses, busy_seen, busy);
      end
      sw_lock = 1'b0;
   endtask

   task automatic test_reset_mid_debounce();
      do_reset(1'b0);
      press(1'b1, 3'd1, "mid_setup");
      btn_next = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      n_checks++;
      if (busy !== 1'b1) begin
         n_fail++;
         $display("FAIL mid_debounce_busy: got busy=%b want 1", busy);
      end
      #2;
      RESET_N = 1'b0;
      #1;
      n_checks++;
      if (flag !== 3'd0 || flag_changed !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL async_reset: got flag=%0d fc=%b busy=%b want 0/0/0", flag, flag_changed, busy);
      end
      btn_next = 1'b0;
      tick();
      RESET_N = 1'b1;
      for (int i = 0; i < 12; i++) tick();
      n_checks++;
      if (flag !== 3'd0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL step_lost: got flag=%0d busy=%b want 0/0", flag, busy);
      end
   endtask

`ifdef AUTO_CYCLE_EN
   task automatic test_auto();
      logic [2:0] exp_seq [5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
      do_reset(1'b1);
      for (int p = 0; p < 5; p++) begin
         for (int i = 0; i < 9; i++) tick();
         n_checks++;
         if (flag_changed !== 1'b0) begin
            n_fail++;
            $display("FAIL auto_early_%0d: got fc=%b want 0", p, flag_changed);
         end
         tick();
         n_checks++;
         if (flag !== exp_seq[p] || flag_changed !== 1'b1) begin
            n_fail++;
            $display("FAIL auto_step_%0d: got flag=%0d fc=%b want %0d/1", p, flag, flag_changed, exp_seq[p]);
         end
      end
      // Button step at edge 7, IDLE again after edge 15, next auto step at edge 25.
      btn_next = 1'b1;
      for (int i = 0; i < 25; i++) begin
         tick();
         if (i == 9) btn_next = 1'b0;
      end
      n_checks++;
      if (flag !== 3'd1) begin
         n_fail++;
         $display("FAIL auto_restart_early: got flag=%0d want 1", flag);
      end
      tick();
      n_checks++;
      if (flag !== 3'd2 || flag_changed !== 1'b1) begin
         n_fail++;
         $display("FAIL auto_restart: got flag=%0d fc=%b want 2/1", flag, flag_changed);
      end
      sw_auto = 1'b0;
   endtask
`else
   task automatic test_auto();
      int pulses = 0;
      do_reset(1'b1);
      for (int i = 0; i < 40; i++) begin
         tick();
         if (flag_changed) pulses++;
      end
      n_checks++;
      if (flag !== 3'd0 || pulses !== 0) begin
         n_fail++;
         $display("FAIL auto_disabled: got flag=%0d pulses=%0d want 0/0", flag, pulses);
      end
      sw_auto = 1'b0;
   endtask
`endif

   initial begin
      test_reset();
      test_latency_hold();
      test_wrap();
      test_glitch();
      test_both_buttons();
      test_lock();
      test_reset_mid_debounce();
      test_auto();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1);
   end

endmodule
`default_nettype wire
